jtag_scan_master: RTL and testbench

- Host-side JTAG initiator that drives TCK/TMS/TDI and samples TDO of a downstream TAP, e.g. the project's TAP data-register block.
- Turns a simple command stream into full TAP traversals: test-logic reset, IR scan, DR scan, and idle clocking.
- Returns captured TDO bits on a response channel.
- Runs on a system clock; TCK is derived by division. Used by the test harness and by the on-chip debug bridge.

---
 rtl/jtag_pkg.sv | 39 +++
 rtl/jtag_tck_gen.sv | 48 ++++
 rtl/jtag_scan_master.sv | 207 ++++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// ------------------------------------------------------------------
// jtag_pkg : shared types and TMS sequences for the JTAG scan master
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package jtag_pkg;

  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_SCAN_IR  = 2'd1,
    OP_SCAN_DR  = 2'd2,
    OP_RUN_IDLE = 2'd3
  } jtag_cmd_op_t;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_HDR   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_TAIL  = 3'd4,
    ST_RUN   = 3'd5,
    ST_RSP   = 3'd6
  } jtag_master_state_t;

  // TMS sequences, bit 0 is driven on the first TCK
  localparam logic [2:0] c_DR_HDR  = 3'b001;
  localparam logic [3:0] c_IR_HDR  = 4'b0011;
  localparam logic [1:0] c_TAIL    = 2'b01;
  localparam logic [5:0] c_TLR_SEQ = 6'b011111;

  // A length of 0 (or anything beyond the data width) means a full-width scan
  function automatic logic [5:0] eff_len(input logic [5:0] len, input logic [5:0] max_len);
    return (len == 6'd0 || len > max_len) ? max_len : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_tck_gen.sv
// ------------------------------------------------------------------
// jtag_tck_gen : divides clk into TCK and flags the clk cycle of each edge
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic trstn,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int              c_CW   = $clog2(CLK_DIV);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

  logic [c_CW-1:0] r_cnt;
  logic            r_tck;
  logic            w_wrap;

  // Strobes are high in the cycle whose clk edge moves tck
  assign w_wrap   = en && (r_cnt == c_LAST);
  assign tck_rise = w_wrap && !r_tck;
  assign tck_fall = w_wrap && r_tck;
  assign tck      = r_tck;

  always_ff @(posedge clk or negedge trstn) begin
    if (!trstn) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (!en) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_tck <= ~r_tck;
    end else begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtag_scan_master.sv
// ------------------------------------------------------------------
// jtag_scan_master : command-driven JTAG initiator (reset, IR/DR scan, idle)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module jtag_scan_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               trstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);

  localparam int c_IW = $clog2(MAX_LEN);

  jtag_master_state_t r_state, w_state_nxt;
  jtag_cmd_op_t       r_op, w_op_nxt;
  logic [5:0]         r_len, w_len_nxt;
  logic [5:0]         r_cnt, w_cnt_nxt, w_cnt_inc, w_hdr_last;
  logic [MAX_LEN-1:0] r_data, w_data_nxt;
  logic [MAX_LEN-1:0] r_rsp_data, w_rsp_nxt;
  logic               r_tms, w_tms_nxt;
  logic               r_tdi, w_tdi_nxt;
  logic               r_init_rsp, w_init_rsp_nxt;
  logic               w_tck_rise, w_tck_fall;

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RSP);
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_RSP);
  assign rsp_data  = r_rsp_data;
  assign tms_o     = r_tms;
  assign tdi_o     = r_tdi;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .trstn    (trstn),
    .en       (busy),
    .tck      (tck_o),
    .tck_rise (w_tck_rise),
    .tck_fall (w_tck_fall)
  );

  always_ff @(posedge clk or negedge trstn) begin
    if (!trstn) begin
      r_state    <= ST_INIT;
      r_op       <= OP_RESET;
      r_len      <= '0;
      r_cnt      <= '0;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_tms      <= 1'b1;
      r_tdi      <= 1'b0;
      r_init_rsp <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_len      <= w_len_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data     <= w_data_nxt;
      r_rsp_data <= w_rsp_nxt;
      r_tms      <= w_tms_nxt;
      r_tdi      <= w_tdi_nxt;
      r_init_rsp <= w_init_rsp_nxt;
    end
  end

  // On each TCK fall the counter advances and TMS/TDI are set up for the next TCK
  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_len_nxt      = r_len;
    w_cnt_nxt      = r_cnt;
    w_data_nxt     = r_data;
    w_rsp_nxt      = r_rsp_data;
    w_tms_nxt      = r_tms;
    w_tdi_nxt      = r_tdi;
    w_init_rsp_nxt = r_init_rsp;
    w_cnt_inc      = r_cnt + 6'd1;
    w_hdr_last     = (r_op == OP_SCAN_IR) ? 6'd3 : 6'd2;

    case (r_state)
      ST_INIT: begin
        if (w_tck_fall) begin
          if (r_cnt == 6'd5) begin
            w_cnt_nxt      = '0;
            w_tms_nxt      = 1'b0;
            w_state_nxt    = r_init_rsp ? ST_RSP : ST_IDLE;
            w_init_rsp_nxt = 1'b0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            w_tms_nxt = c_TLR_SEQ[w_cnt_inc[2:0]];
          end
        end
      end

      ST_IDLE: begin
        if (cmd_valid) begin
          w_op_nxt   = jtag_cmd_op_t'(cmd_op);
          w_len_nxt  = eff_len(cmd_len, 6'(MAX_LEN));
          w_data_nxt = cmd_data;
          w_rsp_nxt  = '0;
          w_cnt_nxt  = '0;
          w_tdi_nxt  = 1'b0;
          case (jtag_cmd_op_t'(cmd_op))
            OP_RESET: begin
              w_state_nxt    = ST_INIT;
              w_init_rsp_nxt = 1'b1;
              w_tms_nxt      = c_TLR_SEQ[0];
            end
            OP_RUN_IDLE: begin
              w_state_nxt = ST_RUN;
              w_tms_nxt   = 1'b0;
            end
            OP_SCAN_IR: begin
              w_state_nxt = ST_HDR;
              w_tms_nxt   = c_IR_HDR[0];
            end
            default: begin
              w_state_nxt = ST_HDR;
              w_tms_nxt   = c_DR_HDR[0];
            end
          endcase
        end
      end

      ST_HDR: begin
        if (w_tck_fall) begin
          if (r_cnt == w_hdr_last) begin
            w_state_nxt = ST_SHIFT;
            w_cnt_nxt   = '0;
            w_tdi_nxt   = r_data[0];
            w_tms_nxt   = (r_len == 6'd1);
          end else begin
            w_cnt_nxt = w_cnt_inc;
            w_tms_nxt = (r_op == OP_SCAN_IR) ? c_IR_HDR[w_cnt_inc[1:0]] : c_DR_HDR[w_cnt_inc[1:0]];
          end
        end
      end

      ST_SHIFT: begin
        if (w_tck_rise) begin
          w_rsp_nxt[r_cnt[c_IW-1:0]] = tdo_i;
        end else if (w_tck_fall) begin
          if (r_cnt == r_len - 6'd1) begin
            w_state_nxt = ST_TAIL;
            w_cnt_nxt   = '0;
            w_tms_nxt   = c_TAIL[0];
            w_tdi_nxt   = 1'b0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            w_tdi_nxt = r_data[w_cnt_inc[c_IW-1:0]];
            w_tms_nxt = (w_cnt_inc == r_len - 6'd1);
          end
        end
      end

      ST_TAIL: begin
        if (w_tck_fall) begin
          if (r_cnt == 6'd1) begin
            w_state_nxt = ST_RSP;
            w_cnt_nxt   = '0;
            w_tms_nxt   = 1'b0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            w_tms_nxt = c_TAIL[1];
          end
        end
      end

      ST_RUN: begin
        if (w_tck_fall) begin
          if (r_cnt == r_len - 6'd1) begin
            w_state_nxt = ST_RSP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

      ST_RSP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_INIT;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_jtag_scan_master.sv
// ------------------------------------------------------------------
// tb_jtag_scan_master : random and directed scans against a TAP / loopback target
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_jtag_scan_master;

  localparam int CLK_DIV = 2;
  localparam int T_CLK   = 10;

  localparam int T_TLR = 0,  T_RTI = 1,  T_SELDR = 2,  T_CAPDR = 3,
                 T_SHDR = 4, T_EX1DR = 5, T_PADR = 6,  T_EX2DR = 7,
                 T_UPDR = 8, T_SELIR = 9, T_CAPIR = 10, T_SHIR = 11,
                 T_EX1IR = 12, T_PAIR = 13, T_EX2IR = 14, T_UPIR = 15;

  localparam logic [3:0]  IDCODE_OP  = 4'b0010;
  localparam logic [31:0] IDCODE_VAL = 32'h0000_010F;

  logic        clk = 1'b0;
  logic        trstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;
  logic        tck_o, tms_o, tdi_o;
  logic        tdo_i = 1'b0;

  int checks = 0;
  int errors = 0;

  jtag_scan_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(32)) dut (
    .clk       (clk),
    .trstn     (trstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .tck_o     (tck_o),
    .tms_o     (tms_o),
    .tdi_o     (tdi_o),
    .tdo_i     (tdo_i)
  );

  always #(T_CLK/2) clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- target model: IEEE 1149.1 TAP or loopback ----------------
  int          tap_st = T_SHDR;
  logic [3:0]  ir = IDCODE_OP, ir_sh = '0;
  logic [31:0] dr_sh = '0;
  logic        lb = 1'b0;
  bit          loopback = 1'b0;

  int          tck_n = 0;
  logic [63:0] obs_tms = '0, obs_tdi = '0;
  time         last_rise = 0;
  int          period_err = 0;
  int          timing_err = 0;

  function automatic int tap_next(input int st, input logic tms);
    case (st)
      T_TLR:   return tms ? T_TLR   : T_RTI;
      T_RTI:   return tms ? T_SELDR : T_RTI;
      T_SELDR: return tms ? T_SELIR : T_CAPDR;
      T_CAPDR: return tms ? T_EX1DR : T_SHDR;
      T_SHDR:  return tms ? T_EX1DR : T_SHDR;
      T_EX1DR: return tms ? T_UPDR  : T_PADR;
      T_PADR:  return tms ? T_EX2DR : T_PADR;
      T_EX2DR: return tms ? T_UPDR  : T_SHDR;
      T_UPDR:  return tms ? T_SELDR : T_RTI;
      T_SELIR: return tms ? T_TLR   : T_CAPIR;
      T_CAPIR: return tms ? T_EX1IR : T_SHIR;
      T_SHIR:  return tms ? T_EX1IR : T_SHIR;
      T_EX1IR: return tms ? T_UPIR  : T_PAIR;
      T_PAIR:  return tms ? T_EX2IR : T_PAIR;
      T_EX2IR: return tms ? T_UPIR  : T_SHIR;
      default: return tms ? T_SELDR : T_RTI;
    endcase
  endfunction

  always @(posedge tck_o) begin
    if (tck_n < 64) begin
      obs_tms[tck_n] = tms_o;
      obs_tdi[tck_n] = tdi_o;
    end
    if (tck_n > 0 && ($time - last_rise) != 2 * CLK_DIV * T_CLK) period_err++;
    last_rise = $time;
    tck_n++;
    lb = tdi_o;
    case (tap_st)
      T_TLR:   ir = IDCODE_OP;
      T_CAPDR: dr_sh = (ir == IDCODE_OP) ? IDCODE_VAL : 32'h0;
      T_SHDR:  dr_sh = (ir == IDCODE_OP) ? {tdi_o, dr_sh[31:1]} : {31'h0, tdi_o};
      T_CAPIR: ir_sh = 4'b0001;
      T_SHIR:  ir_sh = {tdi_o, ir_sh[3:1]};
      T_UPIR:  ir = ir_sh;
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms_o);
  end

  always @(negedge tck_o) begin
    if (loopback)              tdo_i = lb;
    else if (tap_st == T_SHDR) tdo_i = dr_sh[0];
    else if (tap_st == T_SHIR) tdo_i = ir_sh[0];
    else                       tdo_i = 1'b0;
  end

  // TMS/TDI may only move together with a TCK fall while the master is running
  logic p_tms = 1'b1, p_tdi = 1'b0, p_tck = 1'b0, p_busy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (trstn && p_busy && busy && (tms_o !== p_tms || tdi_o !== p_tdi) && !(p_tck && !tck_o))
      timing_err++;
    p_tms  = tms_o;
    p_tdi  = tdi_o;
    p_tck  = tck_o;
    p_busy = busy && trstn;
  end

  task automatic start_rec();
    tck_n      = 0;
    obs_tms    = '0;
    obs_tdi    = '0;
    period_err = 0;
  endtask

  // ---------------- reference: expected TMS stream built from the TAP walk ----------------
  bit exp_q[$];

  task automatic push_bits(input logic [7:0] pat, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pat[i]);
  endtask

  task automatic wait_init(input string tag);
    int  n;
    bit  saw_rsp;
    start_rec();
    n = 0;
    saw_rsp = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1;
      n++;
    end
    check({tag, "_timeout"}, n < 500, 1);
    check({tag, "_tck_count"}, tck_n, 6);
    check({tag, "_tms"}, obs_tms, 64'b011111);
    check({tag, "_tck_period"}, period_err, 0);
    check({tag, "_tap_rti"}, tap_st, T_RTI);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_no_rsp"}, saw_rsp, 0);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", n < 500, 1);
    start_rec();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         input logic [31:0] exp_rsp, input int hold);
    int          n, L, hdr, st_err;
    logic [63:0] exp_tms;
    logic [31:0] mask, obs_shift, stable;
    L    = (len == 0 || len > 32) ? 32 : int'(len);
    mask = (L == 32) ? 32'hFFFF_FFFF : ((32'h1 << L) - 32'h1);
    hdr  = 0;
    exp_q.delete();
    case (op)
      2'd0: push_bits(8'b0001_1111, 6);
      2'd1: begin push_bits(8'b0000_0011, 4); hdr = 4; end
      2'd2: begin push_bits(8'b0000_0001, 3); hdr = 3; end
      default: for (int i = 0; i < L; i++) exp_q.push_back(1'b0);
    endcase
    if (hdr != 0) begin
      for (int i = 0; i < L - 1; i++) exp_q.push_back(1'b0);
      push_bits(8'b0000_0011, 3);
    end
    exp_tms = '0;
    foreach (exp_q[i]) exp_tms[i] = exp_q[i];

    send_cmd(op, len, data);
    n = 0;
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_timeout", n < 2000, 1);
    check("tck_count", tck_n, exp_q.size());
    check("tms_seq", obs_tms, exp_tms);
    check("tck_period", period_err, 0);
    check("rsp_data", rsp_data, exp_rsp);
    check("tap_ends_rti", tap_st, T_RTI);
    check("rsp_cmd_ready", cmd_ready, 0);
    if (hdr != 0) begin
      obs_shift = '0;
      for (int i = 0; i < L; i++) obs_shift[i] = obs_tdi[hdr + i];
      check("tdi_shift", obs_shift, data & mask);
    end

    stable = rsp_data;
    st_err = 0;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'd3;
      cmd_len   = 6'd5;
      @(negedge clk);
      if (!rsp_valid || rsp_data !== stable || cmd_ready || busy) st_err++;
    end
    cmd_valid = 1'b0;
    if (hold > 0) check("backpressure_stable", st_err, 0);

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_released", rsp_valid, 0);
    check("back_to_idle", cmd_ready, 1);
    check("no_extra_tck", tck_n, exp_q.size());
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data, mask, exp_rsp;
    int          n;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_tck", tck_o, 0);
    check("rst_tms", tms_o, 1);
    check("rst_tdi", tdi_o, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 1);
    trstn = 1'b1;
    wait_init("init");

    // IDCODE flow through the TAP model
    loopback = 1'b0;
    run_cmd(2'd1, 6'd4, {28'h0, IDCODE_OP}, 32'h1, 0);
    run_cmd(2'd2, 6'd32, 32'h0, IDCODE_VAL, 0);
    // BYPASS then single-bit DR scan
    run_cmd(2'd1, 6'd4, 32'hF, 32'h1, 0);
    run_cmd(2'd2, 6'd1, 32'h1, 32'h0, 0);

    // len=0 loopback scan and an explicit RESET command
    loopback = 1'b1;
    run_cmd(2'd2, 6'd0, 32'hA5A5_0001, 32'h4B4A_0002, 0);
    run_cmd(2'd0, 6'd9, 32'hFFFF_FFFF, 32'h0, 0);
    // response backpressure with a competing command offered
    run_cmd(2'd2, 6'd12, 32'h0000_0ABC, 32'h0000_0578, 10);

    for (int k = 0; k < 24; k++) begin
      op   = 2'($urandom_range(0, 3));
      len  = 6'($urandom_range(0, 32));
      data = $urandom;
      n    = (len == 0) ? 32 : int'(len);
      mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
      exp_rsp = (op == 2'd1 || op == 2'd2) ? ((data << 1) & mask) : 32'h0;
      run_cmd(op, len, data, exp_rsp, int'($urandom_range(0, 3)));
    end

    // reset during the shift phase of a DR scan
    send_cmd(2'd2, 6'd32, $urandom);
    n = 0;
    while (tck_n < 12 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reach_shift", n < 500, 1);
    @(negedge clk);
    #2;
    trstn = 1'b0;
    #1;
    check("midrst_tck", tck_o, 0);
    check("midrst_tms", tms_o, 1);
    check("midrst_tdi", tdi_o, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_busy", busy, 1);
    repeat (3) @(negedge clk);
    trstn = 1'b1;
    wait_init("reinit");
    repeat (8) @(negedge clk);
    check("reinit_no_stale_rsp", rsp_valid, 0);

    run_cmd(2'd3, 6'd7, 32'h0, 32'h0, 0);
    check("tms_tdi_timing", timing_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
